// File: rtl/reg32_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg32_arb_pkg
//
// Shared definitions for the two-master reg32 Avalon-MM arbiter:
//   - default bus widths (data, byteenable, word address)
//   - the arbiter FSM state encoding
//   - the transfer record latched at grant time and replayed to the slave
//
// The transfer record is sized by the package widths. The top-level
// parameters default to those same widths.
// ---------------------------------------------------------------------------
package reg32_arb_pkg;

  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;
  localparam int ARB_ADDR_W = 2;

  // Every transfer walks IDLE -> ISSUE -> RESP -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // Snapshot of the granted request. Because the request is captured here,
  // the master may drop its strobes after grant without affecting the
  // transfer.
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
    logic [ARB_BE_W-1:0]   be;
    logic                  is_write;
    logic                  master;
  } xfer_t;

  localparam xfer_t XFER_RESET = '{
    addr:     '0,
    data:     '0,
    be:       '0,
    is_write: 1'b0,
    master:   1'b0
  };

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//
// Combinational two-way round-robin picker.
//   req[1:0]    in   request from master 0 / master 1
//   last_grant  in   index of the master that won most recently
//   grant_idx   out  index of the selected master (0 when nothing requests)
//   grant_valid out  at least one master is requesting
//
// A lone requester always wins. On a tie, the master that did not win last
// time is chosen.
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_idx,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    unique case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg32_avalon_arbiter.sv
// ---------------------------------------------------------------------------
// reg32_avalon_arbiter
//
// Shares one byte-enabled 32-bit register slave between two Avalon-MM
// masters: master 0 is the HPS bridge, master 1 is the FPGA-side master.
//
// Ports:
//   clock, reset            sole clock; synchronous active-high reset
//   m<i>_address            master word address
//   m<i>_read, m<i>_write   master request strobes (both set = write)
//   m<i>_writedata          master write data
//   m<i>_byteenable         master write byte lanes
//   m<i>_readdata           registered read data, updated only by that
//                           master's own reads
//   m<i>_waitrequest        low only in the granted master's RESP cycle
//   s_address, s_chipselect,
//   s_read, s_write,
//   s_writedata,
//   s_byteenable            slave side, driven only during ISSUE, else 0
//   s_readdata              combinational read data from the slave
//
// Each transfer takes three cycles: grant and latch in IDLE, one slave
// strobe cycle in ISSUE, then a single completion cycle in RESP.
// ---------------------------------------------------------------------------
module reg32_avalon_arbiter
  import reg32_arb_pkg::*;
#(
  parameter int DATA_W = ARB_DATA_W,
  parameter int BE_W   = ARB_BE_W,
  parameter int ADDR_W = ARB_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,

  output logic [ADDR_W-1:0] s_address,
  output logic              s_chipselect,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic [DATA_W-1:0] s_readdata
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  xfer_t             xfer_q, xfer_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic [1:0]        req;
  logic              grant_idx;
  logic              grant_valid;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_arbiter2 u_rr (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // State register. last_grant resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      xfer_q       <= XFER_RESET;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      xfer_q       <= xfer_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Next-state logic. RESP always returns to IDLE, so a request that is
  // still held there is arbitrated again as a new transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping, transfer latch and read-data capture. The winner's
  // request is snapshotted in IDLE. Read data is captured at the end of
  // ISSUE, while the slave still sees the latched address.
  always_comb begin
    xfer_d       = xfer_q;
    last_grant_d = last_grant_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    if (state_q == IDLE && grant_valid) begin
      last_grant_d  = grant_idx;
      xfer_d.master = grant_idx;
      if (grant_idx) begin
        xfer_d.addr     = m1_address;
        xfer_d.data     = m1_writedata;
        xfer_d.be       = m1_byteenable;
        xfer_d.is_write = m1_write;
      end else begin
        xfer_d.addr     = m0_address;
        xfer_d.data     = m0_writedata;
        xfer_d.be       = m0_byteenable;
        xfer_d.is_write = m0_write;
      end
    end

    if (state_q == ISSUE && !xfer_q.is_write) begin
      if (xfer_q.master) begin
        m1_rdata_d = s_readdata;
      end else begin
        m0_rdata_d = s_readdata;
      end
    end
  end

  // Output logic. The slave bus is quiet outside ISSUE. Each master stalls
  // except during its own RESP cycle.
  always_comb begin
    s_address      = '0;
    s_chipselect   = 1'b0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;

    if (state_q == ISSUE) begin
      s_address    = xfer_q.addr;
      s_chipselect = 1'b1;
      s_write      = xfer_q.is_write;
      s_read       = ~xfer_q.is_write;
      s_writedata  = xfer_q.data;
      s_byteenable = xfer_q.be;
    end

    if (state_q == RESP) begin
      if (xfer_q.master) begin
        m1_waitrequest = 1'b0;
      end else begin
        m0_waitrequest = 1'b0;
      end
    end
  end

  assign m0_readdata = m0_rdata_q;
  assign m1_readdata = m1_rdata_q;

endmodule

// File: tb/tb_reg32_avalon_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg32_avalon_arbiter
//
// Drives the arbiter with directed transfers against a small behavioural
// byte-enabled register slave. Expected values are hand-computed constants
// held in a vector table, plus short hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_reg32_avalon_arbiter;

  logic        clock;
  logic        reset;

  logic [1:0]  m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;

  logic [1:0]  s_address;
  logic        s_chipselect, s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic [31:0] s_readdata;

  int total;
  int bad;

  reg32_avalon_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_writedata   (m0_writedata),
    .m0_byteenable  (m0_byteenable),
    .m0_readdata    (m0_readdata),
    .m0_waitrequest (m0_waitrequest),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_byteenable  (m1_byteenable),
    .m1_readdata    (m1_readdata),
    .m1_waitrequest (m1_waitrequest),
    .s_address      (s_address),
    .s_chipselect   (s_chipselect),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_readdata     (s_readdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural reg32 slave: four byte-enabled words, combinational read.
  logic [31:0] slave_regs [4];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) slave_regs[i] <= '0;
    end else if (s_chipselect && s_write) begin
      for (int b = 0; b < 4; b++) begin
        if (s_byteenable[b]) slave_regs[s_address][b*8 +: 8] <= s_writedata[b*8 +: 8];
      end
    end
  end

  assign s_readdata = slave_regs[s_address];

  typedef struct {
    int          master;
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] mdl_rd [2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_masters();
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
  endtask

  task automatic drive_master(input int m, input bit rd, input bit wr, input logic [1:0] a,
                              input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_address = a; m0_read = rd; m0_write = wr; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_address = a; m1_read = rd; m1_write = wr; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  function automatic logic get_wait(input int m);
    return (m == 0) ? m0_waitrequest : m1_waitrequest;
  endfunction

  function automatic logic [31:0] get_rd(input int m);
    return (m == 0) ? m0_readdata : m1_readdata;
  endfunction

  // Runs one uncontended transfer and checks strobes, latency and data.
  task automatic applyStimulus(input int idx, input vec_t v);
    int          lat;
    int          cs_cycles;
    bit          done;
    logic        cap_wr, cap_rd;
    logic [1:0]  cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    string       tag;

    tag = $sformatf("vec%0d", idx);
    lat = 0; cs_cycles = 0; done = 1'b0;
    cap_wr = 1'b0; cap_rd = 1'b0; cap_addr = '0; cap_wdata = '0; cap_be = '0;

    @(posedge clock); #1;
    drive_master(v.master, !v.wr, v.wr, v.addr, v.data, v.be);

    while (!done && lat < 20) begin
      @(negedge clock);
      lat++;
      if (s_chipselect) begin
        cs_cycles++;
        cap_wr = s_write; cap_rd = s_read; cap_addr = s_address;
        cap_wdata = s_writedata; cap_be = s_byteenable;
      end
      if (!get_wait(v.master)) done = 1'b1;
    end

    checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
    checkOutput({tag, "_cs_cycles"}, 32'(cs_cycles), 32'd1);
    checkOutput({tag, "_s_write"}, {31'd0, cap_wr}, {31'd0, v.wr});
    checkOutput({tag, "_s_read"}, {31'd0, cap_rd}, {31'd0, !v.wr});
    checkOutput({tag, "_s_address"}, {30'd0, cap_addr}, {30'd0, v.addr});
    checkOutput({tag, "_s_byteenable"}, {28'd0, cap_be}, {28'd0, v.be});
    if (v.wr) begin
      checkOutput({tag, "_s_writedata"}, cap_wdata, v.data);
    end else begin
      mdl_rd[v.master] = v.exp_rd;
    end
    checkOutput({tag, "_own_readdata"}, get_rd(v.master), mdl_rd[v.master]);
    checkOutput({tag, "_other_readdata"}, get_rd(1 - v.master), mdl_rd[1 - v.master]);

    @(posedge clock); #1;
    idle_masters();
  endtask

  initial begin
    int         order [4];
    int         when  [4];
    int         n;
    int         cyc;

    total = 0;
    bad   = 0;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;

    vecs[0] = '{master: 0, wr: 1'b1, addr: 2'd1, data: 32'hDEADBEEF, be: 4'b1111, exp_rd: 32'h0};
    vecs[1] = '{master: 0, wr: 1'b0, addr: 2'd1, data: 32'h0,        be: 4'b1111, exp_rd: 32'hDEADBEEF};
    vecs[2] = '{master: 1, wr: 1'b1, addr: 2'd2, data: 32'hFFFFFFFF, be: 4'b1111, exp_rd: 32'h0};
    vecs[3] = '{master: 1, wr: 1'b1, addr: 2'd2, data: 32'h12345678, be: 4'b0011, exp_rd: 32'h0};
    vecs[4] = '{master: 1, wr: 1'b0, addr: 2'd2, data: 32'h0,        be: 4'b1111, exp_rd: 32'hFFFF5678};
    vecs[5] = '{master: 0, wr: 1'b1, addr: 2'd3, data: 32'hAABBCCDD, be: 4'b1100, exp_rd: 32'h0};
    vecs[6] = '{master: 0, wr: 1'b0, addr: 2'd3, data: 32'h0,        be: 4'b1111, exp_rd: 32'hAABB0000};
    vecs[7] = '{master: 1, wr: 1'b0, addr: 2'd1, data: 32'h0,        be: 4'b1111, exp_rd: 32'hDEADBEEF};
    vecs[8] = '{master: 0, wr: 1'b1, addr: 2'd0, data: 32'h11223344, be: 4'b0000, exp_rd: 32'h0};
    vecs[9] = '{master: 0, wr: 1'b0, addr: 2'd0, data: 32'h0,        be: 4'b1111, exp_rd: 32'h00000000};

    // Reset state.
    idle_masters();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_s_chipselect", {31'd0, s_chipselect}, 32'd0);
    checkOutput("rst_s_read", {31'd0, s_read}, 32'd0);
    checkOutput("rst_s_write", {31'd0, s_write}, 32'd0);
    checkOutput("rst_s_address", {30'd0, s_address}, 32'd0);
    checkOutput("rst_s_writedata", s_writedata, 32'd0);
    checkOutput("rst_s_byteenable", {28'd0, s_byteenable}, 32'd0);
    checkOutput("rst_m0_waitrequest", {31'd0, m0_waitrequest}, 32'd1);
    checkOutput("rst_m1_waitrequest", {31'd0, m1_waitrequest}, 32'd1);
    checkOutput("rst_m0_readdata", m0_readdata, 32'd0);
    checkOutput("rst_m1_readdata", m1_readdata, 32'd0);

    for (int i = 0; i < 10; i++) applyStimulus(i, vecs[i]);

    // m0 read whose request is dropped once ISSUE starts still completes.
    @(posedge clock); #1;
    drive_master(0, 1'b1, 1'b0, 2'd1, 32'h0, 4'b1111);
    @(posedge clock); #1;
    idle_masters();
    @(negedge clock);
    checkOutput("drop_issue_cs", {31'd0, s_chipselect}, 32'd1);
    checkOutput("drop_issue_read", {31'd0, s_read}, 32'd1);
    checkOutput("drop_issue_addr", {30'd0, s_address}, 32'd1);
    checkOutput("drop_issue_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    @(negedge clock);
    checkOutput("drop_resp_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
    checkOutput("drop_resp_m0_rdata", m0_readdata, 32'hDEADBEEF);
    @(negedge clock);
    checkOutput("drop_after_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    checkOutput("drop_after_cs", {31'd0, s_chipselect}, 32'd0);

    // Reset during ISSUE discards the transfer without a completion.
    @(posedge clock); #1;
    drive_master(1, 1'b0, 1'b1, 2'd2, 32'h55555555, 4'b1111);
    @(posedge clock); #1;
    idle_masters();
    @(negedge clock);
    checkOutput("rstiss_issue_cs", {31'd0, s_chipselect}, 32'd1);
    checkOutput("rstiss_issue_write", {31'd0, s_write}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rstiss_cs", {31'd0, s_chipselect}, 32'd0);
    checkOutput("rstiss_write", {31'd0, s_write}, 32'd0);
    checkOutput("rstiss_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    checkOutput("rstiss_m0_rdata", m0_readdata, 32'd0);
    checkOutput("rstiss_m1_rdata", m1_readdata, 32'd0);
    @(negedge clock);
    checkOutput("rstiss_next_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    checkOutput("rstiss_next_m0_wait", {31'd0, m0_waitrequest}, 32'd1);

    // Both masters hold requests: grants alternate m0,m1,m0,m1, every 3 cycles.
    n = 0;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin order[i] = -1; when[i] = -1; end
    @(posedge clock); #1;
    drive_master(0, 1'b0, 1'b1, 2'd0, 32'h0A0A0A0A, 4'b1111);
    drive_master(1, 1'b0, 1'b1, 2'd3, 32'h0B0B0B0B, 4'b1111);
    while (n < 4 && cyc < 30) begin
      @(negedge clock);
      cyc++;
      if (!m0_waitrequest && n < 4) begin order[n] = 0; when[n] = cyc; n++; end
      if (!m1_waitrequest && n < 4) begin order[n] = 1; when[n] = cyc; n++; end
    end
    @(posedge clock); #1;
    idle_masters();
    checkOutput("rr_completions", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_grant%0d", i), 32'(order[i]), 32'(i % 2));
      checkOutput($sformatf("rr_cycle%0d", i), 32'(when[i]), 32'(3 * (i + 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
